res_sequencer: RTL and testbench

// - Frame sequencer for the reservoir datapath (input ROM -> 2x pe_8x4_16bit -> 7x16b feedback regs).
// - Replaces the free-running divider/address counter. Steps one input sample at a time through fetch, compute, feedback-load and emit phases.
// - Suppresses reservoir states during the washout period and hands each later state to the readout through a valid/ready handshake.

---
 rtl/res_pkg.sv | 16 +
 rtl/res_sequencer.sv | 106 ++++++++++
 tb/tb_res_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/res_pkg.sv
// res_pkg: state encoding and shared defaults for the reservoir frame sequencer.
package res_pkg;
  localparam int NSAMP_DEF   = 64;
  localparam int WASHOUT_DEF = 8;
  localparam int PE_LAT_DEF  = 4;
  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_CLR     = 8'b0000_0010,
    ST_FETCH   = 8'b0000_0100,
    ST_COMPUTE = 8'b0000_1000,
    ST_LOAD    = 8'b0001_0000,
    ST_EMIT    = 8'b0010_0000,
    ST_NEXT    = 8'b0100_0000,
    ST_DONE    = 8'b1000_0000
  } state_t;
endpackage

// File: rtl/res_sequencer.sv
// res_sequencer: steps one frame of samples through fetch, compute, feedback-load and emit phases.
module res_sequencer
  import res_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int NSAMP   = NSAMP_DEF,
  parameter int ROM_LAT = 1,
  parameter int PE_LAT  = PE_LAT_DEF,
  parameter int WASHOUT = WASHOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pe_ce,
  output logic              fb_clr,
  output logic              fb_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int CNT_W = $clog2(ROM_LAT > PE_LAT ? ROM_LAT : PE_LAT) + 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic emit, last;
  assign emit = {1'b0, rom_addr} >= (ADDR_W+1)'(WASHOUT);
  assign last = rom_addr == ADDR_W'(NSAMP - 1);
  // outputs are registered alongside the state they belong to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rom_addr  <= '0;
      pe_ce     <= 1'b0;
      fb_clr    <= 1'b0;
      fb_load   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      pe_ce   <= 1'b0;
      fb_clr  <= 1'b0;
      fb_load <= 1'b0;
      done    <= 1'b0;
      if (abort && state != ST_IDLE && state != ST_DONE) begin
        state     <= ST_DONE;
        out_valid <= 1'b0;
        done      <= 1'b1;
        aborted   <= 1'b1;
      end else
        case (state)
          ST_IDLE:
            if (start && !abort) begin
              state    <= ST_CLR;
              rom_addr <= '0;
              fb_clr   <= 1'b1;
              busy     <= 1'b1;
            end
          ST_CLR: begin
            state <= ST_FETCH;
            cnt   <= CNT_W'(ROM_LAT - 1);
          end
          ST_FETCH:
            if (cnt == '0) begin
              state <= ST_COMPUTE;
              cnt   <= CNT_W'(PE_LAT - 1);
              pe_ce <= 1'b1;
            end else cnt <= cnt - 1'b1;
          ST_COMPUTE:
            if (cnt == '0) begin
              state   <= ST_LOAD;
              fb_load <= 1'b1;
            end else begin
              cnt   <= cnt - 1'b1;
              pe_ce <= 1'b1;
            end
          ST_LOAD: begin
            state     <= emit ? ST_EMIT : ST_NEXT;
            out_valid <= emit;
          end
          ST_EMIT:
            if (out_ready) begin
              state     <= ST_NEXT;
              out_valid <= 1'b0;
            end
          ST_NEXT:
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_FETCH;
              rom_addr <= rom_addr + 1'b1;
              cnt      <= CNT_W'(ROM_LAT - 1);
            end
          default: begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b0;
          end
        endcase
    end
endmodule

// File: tb/tb_res_sequencer.sv
// tb_res_sequencer: table-driven frame runs with an emitted-address scoreboard plus corner-case sequences.
module tb_res_sequencer;
  logic       clk, rst, start, abort, out_ready;
  logic [5:0] rom_addr;
  logic       pe_ce, fb_clr, fb_load, out_valid, busy, done, aborted;

  res_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(rom_addr),
    .pe_ce(pe_ce), .fb_clr(fb_clr), .fb_load(fb_load), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int stall_addr;
    int stall_n;
    int exp_cycles;
    int exp_emits;
  } vec_t;

  int n_chk, n_fail;
  int q[$];
  int stall_addr, stall_n, stalled, vcnt, pe_viol, n_emit;
  bit pe_chk;
  int run;
  logic [5:0] a0;
  bit stable, prev_pe;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // PE-window checks and scoreboard pops, sampled away from the active edge
  always @(negedge clk) begin
    if (!pe_chk || rst) begin
      run = 0;
      prev_pe = 1'b0;
      stable = 1'b1;
    end else begin
      if (pe_ce) begin
        if (run == 0) a0 = rom_addr;
        else if (rom_addr != a0) stable = 1'b0;
        run++;
      end
      if (prev_pe && !pe_ce) begin
        chk("pe_run_len", run, 4);
        chk("pe_addr_stable", int'(stable), 1);
        chk("fb_load_after_pe", int'(fb_load), 1);
        run = 0;
        stable = 1'b1;
      end
      prev_pe = pe_ce;
    end
    if (!rst && out_valid && out_ready) begin
      n_emit++;
      if (q.size() == 0) chk("sb_unexpected_emit", int'(rom_addr), -1);
      else chk("emit_addr", int'(rom_addr), q.pop_front());
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (out_valid && int'(rom_addr) == stall_addr) begin
        vcnt++;
        if (pe_ce) pe_viol++;
        out_ready = stalled >= stall_n;
        if (!out_ready) stalled++;
      end else out_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic preload(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) q.push_back(a);
  endtask

  initial begin
    vec_t vecs[3];
    int cyc;
    int k;
    vecs[0] = '{-1, 0, 506, 56};
    vecs[1] = '{10, 20, 526, 56};
    vecs[2] = '{63, 5, 511, 56};
    n_chk = 0; n_fail = 0; n_emit = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; pe_chk = 1'b1;
    stall_addr = -1; stall_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({rom_addr, pe_ce, fb_clr, fb_load, out_valid, busy, done, aborted}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      preload(8, 63);
      stall_addr = vecs[i].stall_addr; stall_n = vecs[i].stall_n;
      stalled = 0; vcnt = 0; pe_viol = 0; n_emit = 0;
      pulse_start();
      chk("clr_first", int'(fb_clr), 1);
      wait_done(cyc);
      chk("frame_cycles", cyc, vecs[i].exp_cycles);
      chk("done_not_aborted", int'(aborted), 0);
      chk("emit_count", n_emit, vecs[i].exp_emits);
      chk("sb_drained", q.size(), 0);
      if (stall_addr >= 0) begin
        chk("stall_valid_len", vcnt, stall_n + 1);
        chk("stall_pe_idle", pe_viol, 0);
      end
      @(posedge clk); #1;
      chk("idle_after_done", int'(busy), 0);
      stall_addr = -1;
    end

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_done", int'(done), 0);
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    chk("start_abort_idle", int'({busy, done}), 0);

    // abort during COMPUTE at sample 30
    pe_chk = 1'b0;
    preload(8, 29);
    pulse_start();
    k = 0;
    while (!(pe_ce && rom_addr == 6'd30) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_compute_30", int'(pe_ce && rom_addr == 6'd30), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pe_drop", int'(pe_ce), 0);
    chk("abort_done", int'(done), 1);
    chk("abort_flag", int'(aborted), 1);
    @(posedge clk); #1;
    chk("abort_idle", int'(busy), 0);
    chk("abort_addr_hold", int'(rom_addr), 30);
    chk("abort_sb_drained", q.size(), 0);
    pulse_start();
    chk("restart_clr", int'(fb_clr), 1);
    chk("restart_addr", int'(rom_addr), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_clr", int'({done, aborted}), 3);
    @(posedge clk); #1;
    pe_chk = 1'b1;

    // start held high: two frames back to back
    preload(8, 63); preload(8, 63);
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc);
    chk("b2b_frame1_cycles", cyc, 506);
    @(posedge clk); #1;
    chk("b2b_idle_gap", int'(busy), 0);
    @(posedge clk); #1;
    chk("b2b_clr", int'(fb_clr), 1);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_frame2_cycles", cyc, 506);
    chk("b2b_sb_drained", q.size(), 0);
    @(posedge clk); #1;

    // asynchronous reset while waiting in EMIT
    preload(8, 8);
    out_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_emit", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({rom_addr, pe_ce, fb_clr, fb_load, out_valid, busy, done, aborted}), 0);
    #1;
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'({busy, out_valid}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
